// File: rtl/xma_coef_loader.sv
// rtl/xma_coef_loader.sv - shadow/active coefficient matrix with sync-gated swap
// Optional: XMA_COEF_IDENTITY_RESET_EN loads identity into both banks on reset.
module xma_coef_loader #(
  parameter int NDAC = 4,
  parameter int AW   = 4,
  parameter int CNTW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [31:0]              wr_data,
  input  logic                     commit,
  input  logic                     sync,
  input  logic [AW-1:0]            rd_addr,
  output logic [31:0]              rd_data,
  output logic [NDAC*NDAC*32-1:0]  coef,
  output logic                     pending,
  output logic [CNTW-1:0]          swap_cnt,
  output logic                     wr_err
);

  localparam int N = NDAC * NDAC;
  localparam logic [AW:0] NENT = (AW + 1)'(N);
`ifdef XMA_COEF_IDENTITY_RESET_EN
  localparam bit IDENT = 1'b1;
`else
  localparam bit IDENT = 1'b0;
`endif

  typedef enum logic {IDLE, PENDING} state_t;
  state_t state, state_next;

  logic [31:0] shadow [N];
  logic        wr_in_range;
  logic        wr_ok;
  logic        do_swap;
  logic [31:0] rd_sel;

  function automatic logic [31:0] init_val(input int k);
    return (IDENT && ((k / NDAC) == (k % NDAC))) ? 32'h7FFF_0000 : 32'h0;
  endfunction

  assign wr_in_range = {1'b0, wr_addr} < NENT;
  assign wr_ok       = wr_en && (state == IDLE) && wr_in_range;
  assign do_swap     = (state == PENDING) && sync;
  assign pending     = (state == PENDING);

  // Sync is deliberately ignored in IDLE, so a same-cycle commit+sync waits for the next sync.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (commit) state_next = PENDING;
      PENDING: if (sync)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_sel = 32'h0;
    for (int k = 0; k < N; k++) begin
      if (rd_addr == AW'(k)) rd_sel = shadow[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_data  <= 32'h0;
      swap_cnt <= '0;
      wr_err   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        shadow[k]          <= init_val(k);
        coef[k*32 +: 32]   <= init_val(k);
      end
    end else begin
      state   <= state_next;
      rd_data <= rd_sel;
      wr_err  <= wr_en && ((state == PENDING) || !wr_in_range);
      for (int k = 0; k < N; k++) begin
        if (wr_ok && (wr_addr == AW'(k))) shadow[k] <= wr_data;
      end
      // Whole image moves in one edge; shadow is frozen while PENDING so it is consistent.
      if (do_swap) begin
        for (int k = 0; k < N; k++) coef[k*32 +: 32] <= shadow[k];
        swap_cnt <= swap_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_xma_coef_loader.sv
// tb/tb_xma_coef_loader.sv - scoreboard bench for xma_coef_loader
module tb_xma_coef_loader;

  localparam int NDAC = 4;
  localparam int AW   = 5;
  localparam int CNTW = 4;
  localparam int N    = NDAC * NDAC;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [31:0]      wr_data = '0;
  logic             commit = 1'b0;
  logic             sync = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic [31:0]      rd_data;
  logic [N*32-1:0]  coef;
  logic             pending;
  logic [CNTW-1:0]  swap_cnt;
  logic             wr_err;

  xma_coef_loader #(.NDAC(NDAC), .AW(AW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .sync(sync), .rd_addr(rd_addr), .rd_data(rd_data),
    .coef(coef), .pending(pending), .swap_cnt(swap_cnt), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*32-1:0] coef;
    logic [31:0]     rd;
    logic            err;
    logic            pend;
    logic [CNTW-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  obs_t act_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [31:0]     m_shadow [N];
  logic [31:0]     m_coef   [N];
  logic            m_pend;
  logic [CNTW-1:0] m_cnt;

  function automatic logic [31:0] init_val(input int k);
`ifdef XMA_COEF_IDENTITY_RESET_EN
    if (k == 0 || k == 5 || k == 10 || k == 15) return 32'h7FFF_0000;
`endif
    return 32'h0;
  endfunction

  function automatic logic [N*32-1:0] init_image();
    logic [N*32-1:0] img;
    for (int k = 0; k < N; k++) img[k*32 +: 32] = init_val(k);
    return img;
  endfunction

  function automatic logic [N*32-1:0] model_image();
    logic [N*32-1:0] img;
    for (int k = 0; k < N; k++) img[k*32 +: 32] = m_coef[k];
    return img;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = init_val(k);
      m_coef[k]   = init_val(k);
    end
    m_pend = 1'b0;
    m_cnt  = '0;
    exp_q.delete();
    act_q.delete();
  endtask

  // Drive one cycle, advance the reference model, and record expected/observed outputs.
  task automatic tick(input logic we, input int wa, input logic [31:0] wd,
                      input logic cm, input logic sy, input int ra);
    obs_t e;
    obs_t a;
    wr_en = we; wr_addr = AW'(wa); wr_data = wd; commit = cm; sync = sy; rd_addr = AW'(ra);
    e.err = we && (m_pend || wa >= N);
    e.rd  = (ra < N) ? m_shadow[ra] : 32'h0;
    if (!m_pend && we && wa < N) m_shadow[wa] = wd;
    if (m_pend && sy) begin
      for (int k = 0; k < N; k++) m_coef[k] = m_shadow[k];
      m_cnt  = m_cnt + 1'b1;
      m_pend = 1'b0;
    end else if (!m_pend && cm) begin
      m_pend = 1'b1;
    end
    e.coef = model_image();
    e.pend = m_pend;
    e.cnt  = m_cnt;
    @(posedge clk);
    #1;
    a.coef = coef; a.rd = rd_data; a.err = wr_err; a.pend = pending; a.cnt = swap_cnt;
    exp_q.push_back(e);
    act_q.push_back(a);
    wr_en = 1'b0; commit = 1'b0; sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 32'h0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset();
    obs_t e, a;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (coef !== init_image() || pending !== 1'b0 || swap_cnt !== '0 || rd_data !== 32'h0 || wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: coef=%h pend=%b cnt=%h rd=%h err=%b required init image, 0,0,0,0", coef, pending, swap_cnt, rd_data, wr_err);
    end
    rst = 1'b0;
    model_reset();
    idle(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reset_idle: got cnt=%h pend=%b err=%b rd=%h coef=%h required cnt=%h pend=%b err=%b rd=%h coef=%h",
                 a.cnt, a.pend, a.err, a.rd, a.coef, e.cnt, e.pend, e.err, e.rd, e.coef);
      end
    end
  endtask

  task automatic test_swap();
    obs_t e, a;
    for (int k = 0; k < N; k++) tick(1'b1, k, 32'h0001_0000 * (k + 1), 1'b0, 1'b0, k);
    tick(1'b0, 0, 32'h0, 1'b1, 1'b0, 0);
    idle(5);
    n_chk++;
    if (coef !== init_image()) begin
      n_fail++;
      $display("FAIL swap_before_sync: coef=%h required %h", coef, init_image());
    end
    tick(1'b0, 0, 32'h0, 1'b0, 1'b1, 0);
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (coef[k*32 +: 32] !== 32'h0001_0000 * (k + 1)) begin
        n_fail++;
        $display("FAIL swap_entry%0d: got %h required %h", k, coef[k*32 +: 32], 32'h0001_0000 * (k + 1));
      end
    end
    n_chk++;
    if (swap_cnt !== 4'd1 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_cnt: got cnt=%h pend=%b required 1 0", swap_cnt, pending);
    end
    idle(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL swap_sb: got cnt=%h pend=%b err=%b rd=%h coef=%h required cnt=%h pend=%b err=%b rd=%h coef=%h",
                 a.cnt, a.pend, a.err, a.rd, a.coef, e.cnt, e.pend, e.err, e.rd, e.coef);
      end
    end
  endtask

  task automatic test_frozen();
    obs_t e, a;
    int errs;
    errs = 0;
    tick(1'b0, 0, 32'h0, 1'b1, 1'b0, 0);
    tick(1'b1, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 3);
    errs += int'(wr_err);
    tick(1'b0, 0, 32'h0, 1'b1, 1'b0, 3);
    errs += int'(wr_err);
    tick(1'b0, 0, 32'h0, 1'b0, 1'b1, 3);
    errs += int'(wr_err);
    n_chk++;
    if (errs != 1) begin
      n_fail++;
      $display("FAIL frozen_err_pulses: got %0d required 1", errs);
    end
    n_chk++;
    if (coef[3*32 +: 32] !== 32'h0004_0000 || rd_data === 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL frozen_entry3: coef=%h rd=%h required coef 00040000 and rd not deadbeef", coef[3*32 +: 32], rd_data);
    end
    tick(1'b1, 20, 32'h1111_2222, 1'b0, 1'b0, 20);
    tick(1'b0, 0, 32'h0, 1'b0, 1'b0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL frozen_sb: got cnt=%h pend=%b err=%b rd=%h coef=%h required cnt=%h pend=%b err=%b rd=%h coef=%h",
                 a.cnt, a.pend, a.err, a.rd, a.coef, e.cnt, e.pend, e.err, e.rd, e.coef);
      end
    end
  endtask

  task automatic test_commit_sync_same();
    obs_t e, a;
    logic [CNTW-1:0] c0;
    c0 = swap_cnt;
    tick(1'b1, 7, 32'hCAFE_0007, 1'b1, 1'b1, 7);
    idle(2);
    n_chk++;
    if (pending !== 1'b1 || swap_cnt !== c0) begin
      n_fail++;
      $display("FAIL same_cycle_no_swap: pend=%b cnt=%h required 1 %h", pending, swap_cnt, c0);
    end
    tick(1'b0, 0, 32'h0, 1'b0, 1'b1, 0);
    n_chk++;
    if (swap_cnt !== c0 + 1'b1 || coef[7*32 +: 32] !== 32'hCAFE_0007) begin
      n_fail++;
      $display("FAIL same_cycle_next_sync: cnt=%h coef7=%h required %h cafe0007", swap_cnt, coef[7*32 +: 32], c0 + 1'b1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL same_cycle_sb: got cnt=%h pend=%b err=%b rd=%h coef=%h required cnt=%h pend=%b err=%b rd=%h coef=%h",
                 a.cnt, a.pend, a.err, a.rd, a.coef, e.cnt, e.pend, e.err, e.rd, e.coef);
      end
    end
  endtask

  task automatic test_readback();
    obs_t e, a;
    tick(1'b1, 5, 32'h1234_5678, 1'b0, 1'b0, 5);
    tick(1'b0, 0, 32'h0, 1'b0, 1'b0, 5);
    n_chk++;
    if (rd_data !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL readback5: got %h required 12345678", rd_data);
    end
    tick(1'b1, 15, 32'hA5A5_A5A5, 1'b0, 1'b0, 15);
    tick(1'b0, 0, 32'h0, 1'b0, 1'b0, 15);
    n_chk++;
    if (rd_data !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL readback15: got %h required a5a5a5a5", rd_data);
    end
    tick(1'b0, 0, 32'h0, 1'b0, 1'b0, 16);
    tick(1'b0, 0, 32'h0, 1'b0, 1'b0, 31);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL readback_sb: got cnt=%h pend=%b err=%b rd=%h coef=%h required cnt=%h pend=%b err=%b rd=%h coef=%h",
                 a.cnt, a.pend, a.err, a.rd, a.coef, e.cnt, e.pend, e.err, e.rd, e.coef);
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    obs_t e, a;
    tick(1'b0, 0, 32'h0, 1'b1, 1'b0, 0);
    exp_q.delete();
    act_q.delete();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (pending !== 1'b0 || swap_cnt !== '0 || coef !== init_image()) begin
      n_fail++;
      $display("FAIL async_reset: pend=%b cnt=%h coef=%h required 0 0 %h", pending, swap_cnt, coef, init_image());
    end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    tick(1'b0, 0, 32'h0, 1'b0, 1'b1, 0);
    idle(2);
    n_chk++;
    if (swap_cnt !== '0 || coef !== init_image()) begin
      n_fail++;
      $display("FAIL reset_discards_swap: cnt=%h coef=%h required 0 %h", swap_cnt, coef, init_image());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reset_pend_sb: got cnt=%h pend=%b err=%b rd=%h coef=%h required cnt=%h pend=%b err=%b rd=%h coef=%h",
                 a.cnt, a.pend, a.err, a.rd, a.coef, e.cnt, e.pend, e.err, e.rd, e.coef);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, a;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, i, $urandom, 1'b0, 1'b0, i);
      tick(1'b0, 0, 32'h0, 1'b1, 1'b0, 0);
      tick(1'b0, 0, 32'h0, 1'b0, 1'b1, i);
    end
    n_chk++;
    if (swap_cnt !== '0) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %h required 0", swap_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL wrap_sb: got cnt=%h pend=%b err=%b rd=%h coef=%h required cnt=%h pend=%b err=%b rd=%h coef=%h",
                 a.cnt, a.pend, a.err, a.rd, a.coef, e.cnt, e.pend, e.err, e.rd, e.coef);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_swap();
    test_frozen();
    test_commit_sync_same();
    test_readback();
    test_reset_mid_pending();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xma_coef_loader.md
Name: xma_coef_loader

Overview:
- Upstream coefficient stage for the crosstalk multiply-add: owns the NDAC x NDAC complex coefficient matrix that the multiply-add consumes.
- Host writes land in a shadow bank. A commit arms a swap. The swap copies shadow to active only on a frame-boundary sync strobe, so the datapath never sees a half-updated matrix.
- Also provides shadow readback, a swap counter and a write-error strobe.

Parameters:
- NDAC, 4, matrix dimension (DAC channels); matrix has NDAC*NDAC entries.
- AW, 4, write/read address width; must satisfy 2**AW >= NDAC*NDAC.
- CNTW, 16, swap counter width.

Ports:
- clk  input  1  the single clock for all logic.
- rst  input  1  reset, asynchronous, active-high.
- wr_en  input  1  shadow write strobe, one entry per cycle.
- wr_addr  input  AW  entry index = i*NDAC+j (row i = output channel, column j = input channel).
- wr_data  input  32  entry value {real[31:16], imag[15:0]}, each signed Q1.15.
- commit  input  1  single-cycle pulse that arms a shadow-to-active swap.
- sync  input  1  frame-boundary strobe; a swap may only take effect here.
- rd_addr  input  AW  shadow readback index.
- rd_data  output  32  shadow entry at rd_addr, registered.
- coef  output  NDAC*NDAC*32  active matrix, packed; entry k occupies bits [k*32+31:k*32], k=i*NDAC+j.
- pending  output  1  high while a commit is armed and the swap has not yet occurred.
- swap_cnt  output  CNTW  count of completed swaps.
- wr_err  output  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset values (asynchronous): shadow=0, coef=0, rd_data=0, pending=0, swap_cnt=0, wr_err=0, FSM in IDLE. Reset asserted mid-PENDING discards the armed swap.
- FSM states are IDLE and PENDING. pending is high exactly while the FSM is in PENDING.
- IDLE, write path: wr_en with wr_addr < NDAC*NDAC writes wr_data into shadow[wr_addr] at the next edge. wr_en with wr_addr >= NDAC*NDAC is dropped and pulses wr_err the next cycle.
- IDLE, commit: commit moves the FSM to PENDING at the next edge. If wr_en and commit occur in the same cycle, the write is accepted and is included in the swap.
- IDLE, sync: ignored.
- Commit and sync in the same cycle while in IDLE: only the commit registers. The swap happens at the following sync, never at the same-cycle sync.
- PENDING, write path: every wr_en is dropped and pulses wr_err, so the shadow is frozen while armed. This holds for in-range and out-of-range addresses alike.
- PENDING, commit: a repeated commit is ignored and does not raise an error.
- PENDING, sync, at edge t+1 after the sync cycle t, all in one edge:
  - coef <= full shadow image;
  - swap_cnt <= swap_cnt+1, wrapping modulo 2**CNTW;
  - FSM -> IDLE.
- Swap latency: coef is valid from cycle t+1. The multiply-add re-registers coef internally, so this stage adds exactly one cycle from sync to coef.
- Held outputs: coef never changes except on a swap or reset. No partial updates are permitted.
- rd_data: one-cycle latency from rd_addr, showing shadow contents. A write to X at cycle t is visible when rd_addr=X is presented at t+1. rd_addr >= NDAC*NDAC returns 0.
- wr_err: single-cycle pulse, registered one cycle after the offending wr_en.
- Storage: shadow and active banks are flop arrays, not BRAM, so all entries can be copied in one cycle.

Optional Feature:
- Macro: XMA_COEF_IDENTITY_RESET_EN.
- Defined: reset loads both shadow and active with the identity matrix. Diagonal entries (i==j) are 32'h7FFF0000 (real ~1.0, imag 0); off-diagonal entries are 0. DAC data therefore passes through the multiply-add unmodified straight out of reset.
- Not defined: reset loads all entries with 0, so the datapath outputs zero until the first swap.

Test Plan:
- Reset then idle 10 cycles -> coef all 0 (macro off), or entries 0/5/10/15 = 32'h7FFF0000 and all others 0 (macro on, NDAC=4); pending=0; swap_cnt=0.
- Write addr 0..15 with data 32'h00010000*(k+1), commit, wait 5 cycles, then sync -> coef unchanged before sync; coef[k]=32'h00010000*(k+1) exactly one cycle after sync; pending falls; swap_cnt=1.
- While pending, write addr 3 = 32'hDEADBEEF -> wr_err pulses once; after sync coef[3] holds the pre-commit value; readback of addr 3 is not DEADBEEF.
- Commit and sync in the same IDLE cycle -> no swap that cycle, pending=1; the next sync performs the swap and swap_cnt increments by exactly 1.
- Write addr 5 = 32'h12345678 while rd_addr=5 -> rd_data=32'h12345678 on the second cycle after the write; rd_addr=15 after writing 32'hA5A5A5A5 there -> rd_data matches.
- Assert rst asynchronously mid-PENDING, then release and send sync -> coef stays at reset value, swap_cnt=0; with CNTW=4, 16 swaps -> swap_cnt wraps to 0.
